// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU issue stage: ALU op codes,
//               RV32I opcode and funct7 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OPWIDTH = 5;

    // RV32I major opcodes handled by the issue stage
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;

    // funct7 encodings: base and alternate (SUB/SRA/SRAI)
    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    // ALU op codes, one per instruction
    localparam logic [OPWIDTH-1:0] c_alu_addi  = 5'd0;
    localparam logic [OPWIDTH-1:0] c_alu_slti  = 5'd1;
    localparam logic [OPWIDTH-1:0] c_alu_sltiu = 5'd2;
    localparam logic [OPWIDTH-1:0] c_alu_xori  = 5'd3;
    localparam logic [OPWIDTH-1:0] c_alu_ori   = 5'd4;
    localparam logic [OPWIDTH-1:0] c_alu_andi  = 5'd5;
    localparam logic [OPWIDTH-1:0] c_alu_slli  = 5'd6;
    localparam logic [OPWIDTH-1:0] c_alu_srli  = 5'd7;
    localparam logic [OPWIDTH-1:0] c_alu_srai  = 5'd8;
    localparam logic [OPWIDTH-1:0] c_alu_add   = 5'd9;
    localparam logic [OPWIDTH-1:0] c_alu_sub   = 5'd10;
    localparam logic [OPWIDTH-1:0] c_alu_sll   = 5'd11;
    localparam logic [OPWIDTH-1:0] c_alu_slt   = 5'd12;
    localparam logic [OPWIDTH-1:0] c_alu_sltu  = 5'd13;
    localparam logic [OPWIDTH-1:0] c_alu_xor   = 5'd14;
    localparam logic [OPWIDTH-1:0] c_alu_srl   = 5'd15;
    localparam logic [OPWIDTH-1:0] c_alu_sra   = 5'd16;
    localparam logic [OPWIDTH-1:0] c_alu_or    = 5'd17;
    localparam logic [OPWIDTH-1:0] c_alu_and   = 5'd18;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational RV32I OP / OP-IMM decoder producing the ALU op
//               code, both operands, the destination register and a legal
//               flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]        instr,
    input  logic [WIDTH-1:0]   rs1_data,
    input  logic [WIDTH-1:0]   rs2_data,
    output logic               legal,
    output logic [OPWIDTH-1:0] alu_op,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    output logic [4:0]         rd
);

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_shamt;
    // rs1 field is supplied as data by the register file, not decoded here
    logic             w_unused_rs1_field;

    assign w_opcode           = instr[6:0];
    assign w_funct3           = instr[14:12];
    assign w_funct7           = instr[31:25];
    assign w_imm              = {{(WIDTH-12){instr[31]}}, instr[31:20]};
    assign w_shamt            = {{(WIDTH-5){1'b0}}, instr[24:20]};
    assign w_unused_rs1_field = ^instr[19:15];
    assign rd                 = instr[11:7];
    assign alu_in1            = rs1_data;

    // Decode opcode/funct3/funct7 into op code, second operand and legality
    always_comb begin
        legal   = 1'b0;
        alu_op  = c_alu_addi;
        alu_in2 = rs2_data;
        case (w_opcode)
            c_opc_op_imm: begin
                alu_in2 = w_imm;
                case (w_funct3)
                    3'b000: begin legal = 1'b1; alu_op = c_alu_addi;  end
                    3'b010: begin legal = 1'b1; alu_op = c_alu_slti;  end
                    3'b011: begin legal = 1'b1; alu_op = c_alu_sltiu; end
                    3'b100: begin legal = 1'b1; alu_op = c_alu_xori;  end
                    3'b110: begin legal = 1'b1; alu_op = c_alu_ori;   end
                    3'b111: begin legal = 1'b1; alu_op = c_alu_andi;  end
                    3'b001: begin
                        alu_in2 = w_shamt;
                        if (w_funct7 == c_f7_base) begin
                            legal  = 1'b1;
                            alu_op = c_alu_slli;
                        end
                    end
                    default: begin
                        // funct3 101: logical or arithmetic right shift
                        alu_in2 = w_shamt;
                        if (w_funct7 == c_f7_base) begin
                            legal  = 1'b1;
                            alu_op = c_alu_srli;
                        end else if (w_funct7 == c_f7_alt) begin
                            legal  = 1'b1;
                            alu_op = c_alu_srai;
                        end
                    end
                endcase
            end
            c_opc_op: begin
                if (w_funct7 == c_f7_base) begin
                    legal = 1'b1;
                    case (w_funct3)
                        3'b000:  alu_op = c_alu_add;
                        3'b001:  alu_op = c_alu_sll;
                        3'b010:  alu_op = c_alu_slt;
                        3'b011:  alu_op = c_alu_sltu;
                        3'b100:  alu_op = c_alu_xor;
                        3'b101:  alu_op = c_alu_srl;
                        3'b110:  alu_op = c_alu_or;
                        default: alu_op = c_alu_and;
                    endcase
                end else if (w_funct7 == c_f7_alt) begin
                    if (w_funct3 == 3'b000) begin
                        legal  = 1'b1;
                        alu_op = c_alu_sub;
                    end else if (w_funct3 == 3'b101) begin
                        legal  = 1'b1;
                        alu_op = c_alu_sra;
                    end
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_issue_decode
// Description : ALU issue stage. Decodes OP / OP-IMM instructions, buffers
//               them in an output register plus one skid entry, and counts
//               illegal instructions with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OPWIDTH = alu_pkg::OPWIDTH,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [WIDTH-1:0]   rs1_data,
    input  logic [WIDTH-1:0]   rs2_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPWIDTH-1:0] alu_op,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    output logic [4:0]         rd,
    output logic               illegal_pulse,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic               w_legal;
    logic [OPWIDTH-1:0] w_dec_op;
    logic [WIDTH-1:0]   w_dec_in1;
    logic [WIDTH-1:0]   w_dec_in2;
    logic [4:0]         w_dec_rd;

    logic               w_accept;
    logic               w_enq;
    logic               w_load;

    // Output register (head of the 2-entry buffer)
    logic               r_out_valid;
    logic [OPWIDTH-1:0] r_out_op;
    logic [WIDTH-1:0]   r_out_in1;
    logic [WIDTH-1:0]   r_out_in2;
    logic [4:0]         r_out_rd;

    // Skid entry, only occupied while the output register is stalled
    logic               r_skid_valid;
    logic [OPWIDTH-1:0] r_skid_op;
    logic [WIDTH-1:0]   r_skid_in1;
    logic [WIDTH-1:0]   r_skid_in2;
    logic [4:0]         r_skid_rd;

    logic               r_in_ready;
    logic               r_illegal_pulse;
    logic [CNT_W-1:0]   r_illegal_cnt;

    alu_op_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .legal    (w_legal),
        .alu_op   (w_dec_op),
        .alu_in1  (w_dec_in1),
        .alu_in2  (w_dec_in2),
        .rd       (w_dec_rd)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_enq    = w_accept && w_legal;
    // Output register may take new data when empty or draining this cycle
    assign w_load   = !r_out_valid || out_ready;

    // Two-entry skid buffer: skid drains into the output first, preserving order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_op     <= '0;
            r_out_in1    <= '0;
            r_out_in2    <= '0;
            r_out_rd     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_op    <= '0;
            r_skid_in1   <= '0;
            r_skid_in2   <= '0;
            r_skid_rd    <= '0;
            r_in_ready   <= 1'b1;
        end else if (w_load) begin
            if (r_skid_valid) begin
                // in_ready is low here, so no new item competes for the slot
                r_out_valid  <= 1'b1;
                r_out_op     <= r_skid_op;
                r_out_in1    <= r_skid_in1;
                r_out_in2    <= r_skid_in2;
                r_out_rd     <= r_skid_rd;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_enq) begin
                r_out_valid <= 1'b1;
                r_out_op    <= w_dec_op;
                r_out_in1   <= w_dec_in1;
                r_out_in2   <= w_dec_in2;
                r_out_rd    <= w_dec_rd;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_enq) begin
            r_skid_valid <= 1'b1;
            r_skid_op    <= w_dec_op;
            r_skid_in1   <= w_dec_in1;
            r_skid_in2   <= w_dec_in2;
            r_skid_rd    <= w_dec_rd;
            r_in_ready   <= 1'b0;
        end
    end

    // Flag and count consumed illegal instructions, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_pulse <= 1'b0;
            r_illegal_cnt   <= '0;
        end else begin
            r_illegal_pulse <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_illegal_cnt != c_cnt_max)) begin
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign alu_op        = r_out_op;
    assign alu_in1       = r_out_in1;
    assign alu_in2       = r_out_in2;
    assign rd            = r_out_rd;
    assign illegal_pulse = r_illegal_pulse;
    assign illegal_cnt   = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_decode
// Description : Self-checking bench for alu_issue_decode: directed cases plus
//               randomized traffic against a table-driven reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_decode;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  rd;
    logic        illegal_pulse;
    logic [7:0]  illegal_cnt;

    alu_issue_decode #(
        .WIDTH   (32),
        .OPWIDTH (5),
        .CNT_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_op        (alu_op),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .rd            (rd),
        .illegal_pulse (illegal_pulse),
        .illegal_cnt   (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Legal encoding table, indexed by ALU op code.
    // kind: 0 = sign-extended imm, 1 = shamt, 2 = rs2
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] R = 7'b0110011;
    logic [6:0] t_opc [19] = '{I, I, I, I, I, I, I, I, I, R, R, R, R, R, R, R, R, R, R};
    logic [2:0] t_f3  [19] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5,
                               3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic       t_any [19] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [6:0] t_f7  [19] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20,
                               7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    int         t_kind[19] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};

    typedef struct {
        logic [4:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
    } exp_t;

    // Reference decode: search the table for a matching encoding
    task automatic model_decode(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                                output logic ok, output exp_t e);
        ok = 1'b0;
        e.op = 5'd0; e.in1 = a; e.in2 = b; e.rd = w[11:7];
        for (int i = 0; i < 19; i++) begin
            if (!ok && w[6:0] == t_opc[i] && w[14:12] == t_f3[i] &&
                (t_any[i] || w[31:25] == t_f7[i])) begin
                ok   = 1'b1;
                e.op = 5'(i);
                if (t_kind[i] == 0)      e.in2 = {{20{w[31]}}, w[31:20]};
                else if (t_kind[i] == 1) e.in2 = {27'd0, w[24:20]};
                else                     e.in2 = b;
            end
        end
    endtask

    function automatic logic [31:0] make_legal(input int i);
        logic [31:0] w;
        w = $urandom();
        w[6:0]   = t_opc[i];
        w[14:12] = t_f3[i];
        if (!t_any[i]) w[31:25] = t_f7[i];
        return w;
    endfunction

    // Scoreboard state
    exp_t       q[$];
    logic [4:0] seen_ops[$];
    int         m_cnt  = 0;
    logic       m_pend = 1'b0;
    int         n_xfer = 0;

    // Monitor: compare the DUT against the model once per cycle, then advance it
    always @(negedge clk) begin
        logic ok;
        exp_t e;
        logic acc;
        if (rst) begin
            q.delete();
            m_cnt  = 0;
            m_pend = 1'b0;
        end else begin
            check("illegal_pulse", 32'(illegal_pulse), 32'(m_pend));
            check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0 && out_valid) begin
                check("alu_op", 32'(alu_op), 32'(q[0].op));
                check("alu_in1", alu_in1, q[0].in1);
                check("alu_in2", alu_in2, q[0].in2);
                check("rd", 32'(rd), 32'(q[0].rd));
            end
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                seen_ops.push_back(alu_op);
                n_xfer++;
            end
            m_pend = 1'b0;
            if (acc) begin
                model_decode(instr, rs1_data, rs2_data, ok, e);
                if (ok) q.push_back(e);
                else begin
                    m_pend = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    // Present one instruction and wait (bounded) until it will be accepted
    task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        int budget;
        @(posedge clk); #1;
        in_valid = 1'b1; instr = w; rs1_data = a; rs2_data = b;
        budget = 50;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_in2", alu_in2, 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_pulse", 32'(illegal_pulse), 32'd0);
        check("rst_cnt", 32'(illegal_cnt), 32'd0);
        wait_cycles(2);
        rst = 1'b0;

        // ADDI x1,x0,-5
        send(32'hFFB00093, 32'd7, 32'd0);
        idle();
        @(negedge clk);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_op", 32'(alu_op), 32'd0);
        check("addi_in1", alu_in1, 32'd7);
        check("addi_in2", alu_in2, 32'hFFFFFFFB);
        check("addi_rd", 32'(rd), 32'd1);

        // SUB x3,x1,x2
        send(32'h402081B3, 32'd10, 32'd3);
        idle();
        @(negedge clk);
        check("sub_op", 32'(alu_op), 32'd10);
        check("sub_in1", alu_in1, 32'd10);
        check("sub_in2", alu_in2, 32'd3);
        check("sub_rd", 32'(rd), 32'd3);

        // SRAI x5,x5,31
        send(32'h41F2D293, 32'h80000000, 32'h12345678);
        idle();
        @(negedge clk);
        check("srai_op", 32'(alu_op), 32'd8);
        check("srai_in2", alu_in2, 32'd31);
        check("srai_rd", 32'(rd), 32'd5);

        // Backpressure: three ADDs while the ALU stalls
        wait_cycles(2);
        out_ready = 1'b0;
        base = n_xfer;
        send(32'h002081B3, 32'd100, 32'd1);
        send(32'h002081B3, 32'd200, 32'd2);
        @(posedge clk); #1;
        instr = 32'h002081B3; rs1_data = 32'd300; rs2_data = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_in1", alu_in1, 32'd100);
        @(negedge clk);
        check("bp_hold2_in1", alu_in1, 32'd100);
        check("bp_hold2_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h002081B3, 32'd300, 32'd3);
        idle();
        wait_cycles(4);
        check("bp_xfers", 32'(n_xfer - base), 32'd3);

        // Illegal: branch, then SLLI with bad funct7
        send(32'h00000063, 32'd0, 32'd0);
        send(32'h40101093, 32'd0, 32'd0);
        idle();
        wait_cycles(2);
        check("ill_cnt2", 32'(illegal_cnt), 32'd2);
        check("ill_no_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 300; i++) begin
            send({$urandom()} & 32'hFFFFFF80 | 32'h00000063, 32'd0, 32'd0);
        end
        idle();
        wait_cycles(2);
        check("ill_sat", 32'(illegal_cnt), 32'd255);

        // Sweep every legal encoding back to back
        seen_ops.delete();
        for (int i = 0; i < 19; i++) begin
            send(make_legal(i), $urandom(), $urandom());
        end
        idle();
        wait_cycles(3);
        check("sweep_count", 32'(seen_ops.size()), 32'd19);
        for (int i = 0; i < 19 && i < seen_ops.size(); i++) begin
            check("sweep_op", 32'(seen_ops[i]), 32'(i));
        end

        // Asynchronous reset with two items held
        out_ready = 1'b0;
        send(make_legal(9), 32'd1, 32'd2);
        send(make_legal(3), 32'd3, 32'd4);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_cnt", 32'(illegal_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("arst_no_stale", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rs1_data  = $urandom();
            rs2_data  = $urandom();
            case ($urandom_range(0, 9))
                0, 1, 2:    instr = $urandom();
                3:          instr = make_legal($urandom_range(0, 18)) ^ 32'h40000000;
                default:    instr = make_legal($urandom_range(0, 18));
            endcase
        end
        idle();
        out_ready = 1'b1;
        wait_cycles(4);
        check("final_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
